normal_trigger_front: RTL and testbench

Trigger-output generator for the arbitrary function generator's trigger link; the transmitting end of the normal-trigger path. On a start request it emits a burst of active-low pulses on an idle-high line, with programmable low time, period and pulse count. The receiving end detects each falling edge and toggles its output, so a burst of N pulses yields N toggles downstream. Sits between the control/register block and the trigger output pin.

---
 rtl/normal_trigger_front.sv | 178 +++++++++++++++++
 tb/tb_normal_trigger_front.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/normal_trigger_front.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : normal_trigger_front                                       |
// | Description : Transmitting end of the normal-trigger link. On a start    |
// |               request emits a burst of active-low pulses on an idle-high |
// |               line with programmable low time, period and pulse count.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module normal_trigger_front #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               NTrig_EN,
  input  logic               Trig_Start,
  input  logic [CNT_W-1:0]   Pulse_Low,
  input  logic [CNT_W-1:0]   Pulse_Period,
  input  logic [BURST_W-1:0] Burst_Cnt,
  output logic               Trig_Aout,
  output logic               Busy,
  output logic               Done,
  output logic [BURST_W-1:0] Pulse_Num
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  // Length arithmetic is one bit wider so low_len+1 can never wrap.
  localparam logic [CNT_W:0]   c_LEN_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   c_LOW_MAX = {1'b0, {(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] c_BST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_low_m1,    w_low_m1_nxt;
  logic [CNT_W-1:0]   r_high_m1,   w_high_m1_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [BURST_W-1:0] r_remaining, w_remaining_nxt;
  logic [BURST_W-1:0] r_pulse_num, w_pulse_num_nxt;
  logic               r_start_q,   w_start_q_nxt;
  logic               r_aout,      w_aout_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;

  logic [CNT_W:0]     w_low_ext;
  logic [CNT_W:0]     w_per_ext;
  logic [CNT_W:0]     w_low_len;
  logic [CNT_W:0]     w_low_p1;
  logic [CNT_W:0]     w_per_len;
  logic [CNT_W-1:0]   w_high_len;
  logic [CNT_W-1:0]   w_cfg_low_m1;
  logic [CNT_W-1:0]   w_cfg_high_m1;
  logic               w_accept;

  // Clamp low time to [1, 2^CNT_W-2] and stretch the period so the high
  // phase lasts at least one cycle; both phases are stored as length-1.
  assign w_low_ext     = {1'b0, Pulse_Low};
  assign w_per_ext     = {1'b0, Pulse_Period};
  assign w_low_len     = (w_low_ext == '0)       ? c_LEN_ONE :
                         (w_low_ext > c_LOW_MAX) ? c_LOW_MAX : w_low_ext;
  assign w_low_p1      = w_low_len + c_LEN_ONE;
  assign w_per_len     = (w_per_ext < w_low_p1) ? w_low_p1 : w_per_ext;
  assign w_high_len    = CNT_W'(w_per_len - w_low_len);
  assign w_cfg_low_m1  = w_low_len[CNT_W-1:0] - c_CNT_ONE;
  assign w_cfg_high_m1 = w_high_len - c_CNT_ONE;

  // A start captured in IDLE on the previous edge launches a burst now.
  assign w_accept = r_start_q && (r_state == IDLE) && NTrig_EN && (Burst_Cnt != '0);

  // State, counters and all outputs are registered; reset forces the line high at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_low_m1    <= '0;
      r_high_m1   <= '0;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_pulse_num <= '0;
      r_start_q   <= 1'b0;
      r_aout      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_low_m1    <= w_low_m1_nxt;
      r_high_m1   <= w_high_m1_nxt;
      r_cnt       <= w_cnt_nxt;
      r_remaining <= w_remaining_nxt;
      r_pulse_num <= w_pulse_num_nxt;
      r_start_q   <= w_start_q_nxt;
      r_aout      <= w_aout_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic: phase counters count down to zero.
  always_comb begin
    w_state_nxt     = r_state;
    w_low_m1_nxt    = r_low_m1;
    w_high_m1_nxt   = r_high_m1;
    w_cnt_nxt       = r_cnt;
    w_remaining_nxt = r_remaining;
    w_pulse_num_nxt = r_pulse_num;
    w_start_q_nxt   = 1'b0;
    w_aout_nxt      = r_aout;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;

    if (!NTrig_EN) begin
      // Disable aborts everything; pulse count is left for inspection.
      w_state_nxt = IDLE;
      w_aout_nxt  = 1'b1;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_aout_nxt = 1'b1;
          w_busy_nxt = 1'b0;
          if (w_accept) begin
            w_low_m1_nxt    = w_cfg_low_m1;
            w_high_m1_nxt   = w_cfg_high_m1;
            w_remaining_nxt = Burst_Cnt;
            w_cnt_nxt       = w_cfg_low_m1;
            w_pulse_num_nxt = c_BST_ONE;
            w_aout_nxt      = 1'b0;
            w_busy_nxt      = 1'b1;
            w_state_nxt     = LOW;
          end else begin
            w_start_q_nxt = Trig_Start;
          end
        end
        LOW: begin
          if (r_cnt == '0) begin
            w_cnt_nxt   = r_high_m1;
            w_aout_nxt  = 1'b1;
            w_state_nxt = HIGH;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end
        HIGH: begin
          if (r_cnt == '0) begin
            w_remaining_nxt = r_remaining - c_BST_ONE;
            if (r_remaining == c_BST_ONE) begin
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_cnt_nxt       = r_low_m1;
              w_aout_nxt      = 1'b0;
              w_pulse_num_nxt = r_pulse_num + c_BST_ONE;
              w_state_nxt     = LOW;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          w_aout_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign Trig_Aout = r_aout;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Pulse_Num = r_pulse_num;

endmodule
`default_nettype wire

// File: tb/tb_normal_trigger_front.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_normal_trigger_front                                    |
// | Description : Directed self-checking bench for normal_trigger_front,     |
// |               with a line monitor and a toggle-on-fall receiver model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_normal_trigger_front;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic               Clock = 1'b0;
  logic               Reset = 1'b0;
  logic               NTrig_EN = 1'b0;
  logic               Trig_Start = 1'b0;
  logic [CNT_W-1:0]   Pulse_Low = '0;
  logic [CNT_W-1:0]   Pulse_Period = '0;
  logic [BURST_W-1:0] Burst_Cnt = '0;
  logic               Trig_Aout;
  logic               Busy;
  logic               Done;
  logic [BURST_W-1:0] Pulse_Num;

  int n_tests = 0;
  int n_fail  = 0;

  normal_trigger_front #(.CNT_W(CNT_W), .BURST_W(BURST_W)) u_dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .NTrig_EN     (NTrig_EN),
    .Trig_Start   (Trig_Start),
    .Pulse_Low    (Pulse_Low),
    .Pulse_Period (Pulse_Period),
    .Burst_Cnt    (Burst_Cnt),
    .Trig_Aout    (Trig_Aout),
    .Busy         (Busy),
    .Done         (Done),
    .Pulse_Num    (Pulse_Num)
  );

  always #5 Clock = ~Clock;

  // Line monitor: busy/done cycle counts, fall spacing, low widths, receiver.
  int   m_cyc = 0, m_busy = 0, m_done = 0, m_falls = 0, m_last_fall = 0;
  int   m_gap = 0, m_min_gap = 0, m_max_gap = 0;
  int   m_low_run = 0, m_min_low = 0, m_max_low = 0;
  int   rx_toggles = 0;
  logic m_prev = 1'b1;
  logic rx_out = 1'b0;
  logic rx_start = 1'b0;

  always @(negedge Clock) begin
    m_cyc++;
    if (Busy === 1'b1) m_busy++;
    if (Done === 1'b1) m_done++;
    if (m_prev === 1'b1 && Trig_Aout === 1'b0) begin
      if (m_falls > 0) begin
        m_gap = m_cyc - m_last_fall;
        if (m_gap < m_min_gap) m_min_gap = m_gap;
        if (m_gap > m_max_gap) m_max_gap = m_gap;
      end
      m_falls++;
      m_last_fall = m_cyc;
      rx_out = ~rx_out;
      rx_toggles++;
    end
    if (Trig_Aout === 1'b0) m_low_run++;
    else if (m_low_run > 0) begin
      if (m_low_run < m_min_low) m_min_low = m_low_run;
      if (m_low_run > m_max_low) m_max_low = m_low_run;
      m_low_run = 0;
    end
    m_prev = Trig_Aout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_clr();
    m_busy = 0; m_done = 0; m_falls = 0; m_last_fall = 0;
    m_min_gap = 99999; m_max_gap = 0;
    m_low_run = 0; m_min_low = 99999; m_max_low = 0;
    rx_toggles = 0; rx_start = rx_out;
  endtask

  task automatic pulse_start(input bit clr);
    @(posedge Clock); #1;
    if (clr) mon_clr();
    Trig_Start = 1'b1;
    @(posedge Clock); #1;
    Trig_Start = 1'b0;
  endtask

  // Start with fresh monitor and check the one-cycle launch latency.
  task automatic start_req(input string t);
    pulse_start(1'b1);
    @(negedge Clock);
    chk({t, "_lat_aout"}, Trig_Aout, 1);
    chk({t, "_lat_busy"}, Busy, 0);
    @(negedge Clock);
    chk({t, "_go_aout"}, Trig_Aout, 0);
    chk({t, "_go_busy"}, Busy, 1);
    chk({t, "_go_pnum"}, Pulse_Num, 1);
  endtask

  // Returns at the negedge where Done is seen (or after the budget expires).
  task automatic wait_done(input string t, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) seen = 1'b1;
    end
    chk({t, "_done_seen"}, seen, 1);
  endtask

  task automatic tail(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #1 Reset = 1'b1;
    tail(3);
    chk("rst_aout", Trig_Aout, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_pnum", Pulse_Num, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    NTrig_EN = 1'b1;
    tail(2);

    // Basic burst: 4 pulses, 3 low, period 10.
    Pulse_Low = 16'd3; Pulse_Period = 16'd10; Burst_Cnt = 8'd4;
    start_req("b1");
    wait_done("b1", 100);
    chk("b1_pnum_done", Pulse_Num, 4);
    chk("b1_busy_done", Busy, 0);
    chk("b1_aout_done", Trig_Aout, 1);
    tail(3);
    chk("b1_falls", m_falls, 4);
    chk("b1_low_min", m_min_low, 3);
    chk("b1_low_max", m_max_low, 3);
    chk("b1_gap_min", m_min_gap, 10);
    chk("b1_gap_max", m_max_gap, 10);
    chk("b1_busy_cyc", m_busy, 40);
    chk("b1_done_cnt", m_done, 1);

    // Clamped minimum: 1 low, 1 high.
    Pulse_Low = 16'd0; Pulse_Period = 16'd0; Burst_Cnt = 8'd2;
    start_req("cl");
    wait_done("cl", 50);
    tail(3);
    chk("cl_falls", m_falls, 2);
    chk("cl_low_max", m_max_low, 1);
    chk("cl_gap", m_min_gap, 2);
    chk("cl_busy_cyc", m_busy, 4);
    chk("cl_done_cnt", m_done, 1);
    chk("cl_pnum", Pulse_Num, 2);

    // Zero burst count is ignored.
    Burst_Cnt = 8'd0;
    pulse_start(1'b1);
    tail(10);
    chk("z_busy_cyc", m_busy, 0);
    chk("z_done_cnt", m_done, 0);
    chk("z_falls", m_falls, 0);
    chk("z_aout", Trig_Aout, 1);

    // Start while busy is ignored; config changes mid-burst ignored.
    Pulse_Low = 16'd2; Pulse_Period = 16'd5; Burst_Cnt = 8'd3;
    start_req("ib");
    Burst_Cnt = 8'd7; Pulse_Low = 16'd1;
    pulse_start(1'b0);
    wait_done("ib", 60);
    chk("ib_pnum", Pulse_Num, 3);
    tail(10);
    chk("ib_falls", m_falls, 3);
    chk("ib_low_max", m_max_low, 2);
    chk("ib_gap_max", m_max_gap, 5);
    chk("ib_busy_cyc", m_busy, 15);
    chk("ib_done_cnt", m_done, 1);

    // Disable during the 3rd pulse's low phase.
    Pulse_Low = 16'd4; Pulse_Period = 16'd8; Burst_Cnt = 8'd5;
    start_req("ab");
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clock);
      if (Pulse_Num == 8'd3 && Trig_Aout === 1'b0) found = 1'b1;
    end
    chk("ab_found", found, 1);
    @(posedge Clock); #1;
    NTrig_EN = 1'b0;
    @(negedge Clock);
    chk("ab_pre_aout", Trig_Aout, 0);
    @(negedge Clock);
    chk("ab_aout", Trig_Aout, 1);
    chk("ab_busy", Busy, 0);
    chk("ab_pnum", Pulse_Num, 3);
    tail(20);
    chk("ab_done_cnt", m_done, 0);
    chk("ab_falls", m_falls, 3);
    chk("ab_busy_cyc", m_busy, 18);
    NTrig_EN = 1'b1;

    // Asynchronous reset mid-low, then a full burst afterwards.
    Pulse_Low = 16'd5; Pulse_Period = 16'd9; Burst_Cnt = 8'd3;
    start_req("rs");
    @(posedge Clock); #2;
    Reset = 1'b1;
    #1;
    chk("rs_async_aout", Trig_Aout, 1);
    chk("rs_async_busy", Busy, 0);
    chk("rs_async_pnum", Pulse_Num, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    tail(2);
    start_req("rs2");
    wait_done("rs2", 80);
    tail(3);
    chk("rs2_falls", m_falls, 3);
    chk("rs2_low_min", m_min_low, 5);
    chk("rs2_gap_min", m_min_gap, 9);
    chk("rs2_busy_cyc", m_busy, 27);
    chk("rs2_done_cnt", m_done, 1);

    // Receiver loopback and back-to-back start in the Done cycle.
    Pulse_Low = 16'd1; Pulse_Period = 16'd3; Burst_Cnt = 8'd3;
    start_req("bb");
    wait_done("bb", 40);
    chk("bb_rx_toggles1", rx_toggles, 3);
    Trig_Start = 1'b1;
    @(posedge Clock); #1;
    Trig_Start = 1'b0;
    @(negedge Clock);
    chk("bb2_lat_aout", Trig_Aout, 1);
    chk("bb2_lat_busy", Busy, 0);
    @(negedge Clock);
    chk("bb2_go_aout", Trig_Aout, 0);
    chk("bb2_go_busy", Busy, 1);
    chk("bb2_go_pnum", Pulse_Num, 1);
    wait_done("bb2", 40);
    tail(3);
    chk("bb_falls", m_falls, 6);
    chk("bb_rx_toggles", rx_toggles, 6);
    chk("bb_rx_parity", rx_out, rx_start);
    chk("bb_done_cnt", m_done, 2);
    chk("bb_busy_cyc", m_busy, 18);
    chk("bb_pnum", Pulse_Num, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
